ibex_pext_mult_arbiter: RTL and testbench

// Shares the single 17x17x4 signed multiplier array in EX between two requesters:
//   - RV32M multiply requests (M)
//   - P-ext Zpn multiply requests (P: ops that assert zpn_mult_sel)

---
 rtl/ibex_pext_mult_arbiter.sv | 142 ++++++++++++++
 tb/tb_ibex_pext_mult_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pext_mult_arbiter.sv
// rtl/ibex_pext_mult_arbiter.sv - shared 17x17x4 multiplier arbiter for RV32M and P-ext Zpn ops (optional PEXT_MULT_PERF_CNT_EN)
module ibex_pext_mult_arbiter #(
   parameter bit          RoundRobin  = 1'b1,
   parameter int unsigned MulPasses32 = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_m_i,
   input  logic       req_p_i,
   input  logic [1:0] p_class_i,
   input  logic       p_acc_i,
   input  logic       kill_i,
   output logic       gnt_m_o,
   output logic       gnt_p_o,
   output logic       valid_m_o,
   output logic       valid_p_o,
   output logic       mul_en_o,
   output logic [1:0] mul_pass_o,
   output logic       acc_en_o,
   output logic       busy_o
`ifdef PEXT_MULT_PERF_CNT_EN
   ,
   output logic [15:0] perf_conflict_o
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [1:0] PASSES32 = MulPasses32[1:0];

   logic [1:0] state_q;
   logic       owner_p_q;   // 1: P owns the array, 0: M owns it
   logic       last_p_q;    // owner of the last completed op, for tie-breaking
   logic       acc_q;
   logic [1:0] npass_q;
   logic [1:0] pass_q;

   logic       accept;
   logic       pick_p;
   logic [1:0] new_npass;

   // Pick the winner among the raw requests seen in IDLE and its pass count
   always_comb begin
      accept    = 1'b0;
      pick_p    = 1'b0;
      new_npass = PASSES32;
      if (!kill_i && (req_m_i || req_p_i)) begin
         accept = 1'b1;
      end
      if (req_m_i && req_p_i) begin
         pick_p = RoundRobin ? !last_p_q : 1'b0;
      end else begin
         pick_p = req_p_i;
      end
      if (pick_p) begin
         case (p_class_i)
            2'd0, 2'd1: new_npass = 2'd1;
            2'd2:       new_npass = 2'd2;
            default:    new_npass = PASSES32;
         endcase
      end
   end

   // Op sequencer: accept, step through array passes, optional accumulate, complete
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_p_q <= 1'b0;
         last_p_q  <= 1'b1;
         acc_q     <= 1'b0;
         npass_q   <= 2'd1;
         pass_q    <= 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               pass_q <= 2'd0;
               if (accept) begin
                  state_q   <= EXEC;
                  owner_p_q <= pick_p;
                  npass_q   <= new_npass;
                  acc_q     <= pick_p & p_acc_i;
               end
            end
            EXEC: begin
               if (kill_i) begin
                  state_q <= IDLE;
                  pass_q  <= 2'd0;
               end else if (pass_q == npass_q - 2'd1) begin
                  pass_q  <= 2'd0;
                  state_q <= acc_q ? ACC : DONE;
               end else begin
                  pass_q <= pass_q + 2'd1;
               end
            end
            ACC: begin
               state_q <= kill_i ? IDLE : DONE;
            end
            DONE: begin
               state_q <= IDLE;
               // A killed completion never happened as far as fairness is concerned
               if (!kill_i) begin
                  last_p_q <= owner_p_q;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign gnt_m_o    = busy_o && !owner_p_q;
   assign gnt_p_o    = busy_o && owner_p_q;
   assign mul_en_o   = (state_q == EXEC);
   assign mul_pass_o = (state_q == EXEC) ? pass_q : 2'd0;
   assign acc_en_o   = (state_q == ACC);
   assign valid_m_o  = (state_q == DONE) && !owner_p_q && !kill_i && !rst_i;
   assign valid_p_o  = (state_q == DONE) && owner_p_q && !kill_i && !rst_i;

`ifdef PEXT_MULT_PERF_CNT_EN
   logic [15:0] perf_q;
   logic        conflict;

   assign conflict = busy_o ? (owner_p_q ? req_m_i : req_p_i) : (req_m_i && req_p_i);

   // Saturating count of cycles where a requester is left waiting
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= 16'd0;
      end else if (conflict && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_conflict_o = perf_q;
`endif

endmodule

// File: tb/tb_ibex_pext_mult_arbiter.sv
// tb/tb_ibex_pext_mult_arbiter.sv - self-checking bench for ibex_pext_mult_arbiter
module tb_ibex_pext_mult_arbiter;

   localparam int MP32 = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_m = 1'b0;
   logic       req_p = 1'b0;
   logic [1:0] p_class = 2'd0;
   logic       p_acc = 1'b0;
   logic       kill = 1'b0;

   logic       gnt_m, gnt_p, valid_m, valid_p, mul_en, acc_en, busy;
   logic [1:0] mul_pass;
   logic       f_gnt_m, f_gnt_p, f_valid_m, f_valid_p, f_mul_en, f_acc_en, f_busy;
   logic [1:0] f_mul_pass;
`ifdef PEXT_MULT_PERF_CNT_EN
   logic [15:0] perf, f_perf;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   ibex_pext_mult_arbiter #(.RoundRobin(1'b1), .MulPasses32(MP32)) dut (
      .clk_i(clk), .rst_i(rst), .req_m_i(req_m), .req_p_i(req_p),
      .p_class_i(p_class), .p_acc_i(p_acc), .kill_i(kill),
      .gnt_m_o(gnt_m), .gnt_p_o(gnt_p), .valid_m_o(valid_m), .valid_p_o(valid_p),
      .mul_en_o(mul_en), .mul_pass_o(mul_pass), .acc_en_o(acc_en), .busy_o(busy)
`ifdef PEXT_MULT_PERF_CNT_EN
      , .perf_conflict_o(perf)
`endif
   );

   ibex_pext_mult_arbiter #(.RoundRobin(1'b0), .MulPasses32(MP32)) dut_fixed (
      .clk_i(clk), .rst_i(rst), .req_m_i(req_m), .req_p_i(req_p),
      .p_class_i(p_class), .p_acc_i(p_acc), .kill_i(kill),
      .gnt_m_o(f_gnt_m), .gnt_p_o(f_gnt_p), .valid_m_o(f_valid_m), .valid_p_o(f_valid_p),
      .mul_en_o(f_mul_en), .mul_pass_o(f_mul_pass), .acc_en_o(f_acc_en), .busy_o(f_busy)
`ifdef PEXT_MULT_PERF_CNT_EN
      , .perf_conflict_o(f_perf)
`endif
   );

   // Reference model: each accepted op becomes a precomputed timeline of per-cycle outputs
   typedef struct packed {
      logic       mul_en;
      logic [1:0] pass;
      logic       acc_en;
      logic       valid;
   } step_t;

   step_t q[$];
   bit    m_busy = 1'b0;
   bit    m_owner_p = 1'b0;
   bit    m_last_p = 1'b1;
   int    m_perf = 0;

   function automatic logic [8:0] obs_vec();
      return {gnt_m, gnt_p, valid_m, valid_p, mul_en, mul_pass, acc_en, busy};
   endfunction

   function automatic logic [8:0] exp_vec();
      step_t f;
      if (!m_busy) return 9'd0;
      f = q[0];
      return {!m_owner_p, m_owner_p,
              f.valid && !m_owner_p && !kill && !rst,
              f.valid && m_owner_p && !kill && !rst,
              f.mul_en, f.pass, f.acc_en, 1'b1};
   endfunction

   task automatic model_update();
      step_t f;
      int    np;
      bit    acc;
      if (rst) begin
         m_busy = 1'b0;
         q.delete();
         m_last_p = 1'b1;
         m_perf = 0;
      end else begin
         if ((m_busy && (m_owner_p ? req_m : req_p)) || (!m_busy && req_m && req_p))
            if (m_perf < 65535) m_perf++;
         if (m_busy) begin
            if (kill) begin
               m_busy = 1'b0;
               q.delete();
            end else begin
               f = q.pop_front();
               if (f.valid) m_last_p = m_owner_p;
               if (q.size() == 0) m_busy = 1'b0;
            end
         end else if (!kill && (req_m || req_p)) begin
            if (req_m && req_p) m_owner_p = !m_last_p;
            else                m_owner_p = req_p;
            if (!m_owner_p)         np = MP32;
            else if (p_class <= 1)  np = 1;
            else if (p_class == 2)  np = 2;
            else                    np = MP32;
            acc = m_owner_p && p_acc;
            for (int i = 0; i < np; i++) q.push_back('{1'b1, 2'(i), 1'b0, 1'b0});
            if (acc) q.push_back('{1'b0, 2'd0, 1'b1, 1'b0});
            q.push_back('{1'b0, 2'd0, 1'b0, 1'b1});
            m_busy = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; req_m = 1'b0; req_p = 1'b0; kill = 1'b0; p_class = 2'd0; p_acc = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_m = 1'b1; req_p = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (obs_vec() !== 9'd0) $display("FAIL reset_outputs got=%b exp=%b", obs_vec(), 9'd0);
      else passed++;
      rst = 1'b0; req_m = 1'b0; req_p = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_idle busy got=%b exp=0", busy);
      else passed++;
   endtask

   task automatic test_single_p();
      apply_reset();
      req_p = 1'b1; p_class = 2'd1; p_acc = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL single_p cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
         checks++;
         if ({gnt_p, valid_p} !== {(c == 1 || c == 2), (c == 2)})
            $display("FAIL single_p_timing cyc=%0d got=%b exp=%b", c, {gnt_p, valid_p}, {(c == 1 || c == 2), (c == 2)});
         else passed++;
         tick();
         if (c == 2) req_p = 1'b0;
      end
   endtask

   task automatic test_tie_rr();
      apply_reset();
      req_m = 1'b1; req_p = 1'b1; p_class = 2'd1; p_acc = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL tie_rr cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
         checks++;
         if ({valid_m, gnt_p, valid_p} !== {(c == 3), (c == 5 || c == 6), (c == 6)})
            $display("FAIL tie_rr_order cyc=%0d got=%b exp=%b", c, {valid_m, gnt_p, valid_p}, {(c == 3), (c == 5 || c == 6), (c == 6)});
         else passed++;
         tick();
         if (c == 6) begin req_m = 1'b0; req_p = 1'b0; end
      end
   endtask

   task automatic test_acc_p();
      apply_reset();
      req_p = 1'b1; p_class = 2'd3; p_acc = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL acc_p cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
         checks++;
         if ({mul_en, mul_pass, acc_en, valid_p} !== {(c == 1 || c == 2), 2'((c == 2) ? 1 : 0), (c == 3), (c == 4)})
            $display("FAIL acc_p_seq cyc=%0d got=%b exp=%b", c, {mul_en, mul_pass, acc_en, valid_p},
                     {(c == 1 || c == 2), 2'((c == 2) ? 1 : 0), (c == 3), (c == 4)});
         else passed++;
         tick();
         if (c == 4) req_p = 1'b0;
      end
   endtask

   task automatic test_kill();
      apply_reset();
      req_m = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL kill cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
         checks++;
         if (valid_m !== 1'b0) $display("FAIL kill_no_valid cyc=%0d got=%b exp=0", c, valid_m);
         else passed++;
         if (c == 3) begin
            checks++;
            if ({gnt_m, busy} !== 2'b00) $display("FAIL kill_release got=%b exp=00", {gnt_m, busy});
            else passed++;
         end
         tick();
         if (c == 1) kill = 1'b1;
         if (c == 2) begin kill = 1'b0; req_m = 1'b0; end
      end
   endtask

   task automatic test_fixed_priority();
      int nvalid;
      nvalid = 0;
      apply_reset();
      req_m = 1'b1; req_p = 1'b1; p_class = 2'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (f_valid_m) nvalid++;
         checks++;
         if (f_gnt_p !== 1'b0 || f_valid_p !== 1'b0)
            $display("FAIL fixed_p_granted cyc=%0d got=%b exp=00", c, {f_gnt_p, f_valid_p});
         else passed++;
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL fixed_rr_side cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
         tick();
      end
      req_m = 1'b0; req_p = 1'b0;
      checks++;
      if (nvalid !== 5) $display("FAIL fixed_m_count got=%0d exp=5", nvalid);
      else passed++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%b exp=%b", c, obs_vec(), exp_vec());
         else passed++;
`ifdef PEXT_MULT_PERF_CNT_EN
         checks++;
         if (perf !== 16'(m_perf)) $display("FAIL perf cyc=%0d got=%0d exp=%0d", c, perf, m_perf);
         else passed++;
`endif
         tick();
         rst  = ($urandom_range(0, 59) == 0);
         kill = ($urandom_range(0, 11) == 0);
         req_m = (m_busy && !m_owner_p) ? 1'b1 : ($urandom_range(0, 2) != 0);
         req_p = (m_busy && m_owner_p) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (!(m_busy && m_owner_p)) begin
            p_class = 2'($urandom_range(0, 3));
            p_acc   = $urandom_range(0, 1) != 0;
         end
      end
      rst = 1'b0; kill = 1'b0; req_m = 1'b0; req_p = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_p();
      test_tie_rr();
      test_acc_p();
      test_kill();
      test_fixed_priority();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
